instruction_fetch_stage: RTL
============================

// Module: instruction_fetch_stage
// PURPOSE
//  Parametrised IF stage: owns PC, drives sync instruction memory (1-cycle read), hands
//  instr + PC+INC to IF/ID with a valid flag. Adds over previous fetch: sync reset,
//  stall with skid hold of in-flight word, branch redirect with bubble, configurable widths.
//  Sits between PC-select logic/branch unit and the IF/ID pipeline register.
// PARAMETERS
//  DATA_W    32  width of PC, branch target, instruction word
//  ADDR_W    10  instruction memory address width (word-addressed)
//  PC_INC    1   PC increment per fetch (word addressing)
//  RESET_PC  0   PC value after reset
// PORTS
//  clk            in   1       clock, all state on rising edge
//  rst            in   1       synchronous reset, active-high
//  stall          in   1       hold PC and current output (downstream not ready)
//  branch_taken   in   1       redirect fetch to branch_target, flush in-flight word
//  branch_target  in   DATA_W  redirect PC
//  imem_addr      out  ADDR_W  memory address = pc[ADDR_W-1:0], combinational
//  imem_data      in   DATA_W  memory read data, valid 1 cycle after imem_addr
//  pc_debug       out  DATA_W  current fetch PC (pc register)
//  pc_plus        out  DATA_W  PC+PC_INC of word on instr (registered)
//  instr          out  DATA_W  fetched instruction; 0 when instr_valid=0
//  instr_valid    out  1       instr/pc_plus hold a real fetched word
// BEHAVIOUR
//  State: pc, pc_plus_r, fetch_valid, hold_valid, hold_instr.
//  Priority per edge: rst > branch_taken > stall > advance.
//  Reset: pc=RESET_PC, pc_plus=0, fetch_valid=0, hold_valid=0, hold_instr=0 -> instr_valid=0,
//   instr=0, pc_debug=RESET_PC. Reset mid-stall/mid-branch discards everything.
//  Advance (no stall, no branch): pc<=pc+PC_INC; pc_plus<=pc+PC_INC; fetch_valid<=1;
//   hold_valid<=0. Latency: address issued cycle n -> instr/instr_valid cycle n+1.
//  Output mux: instr = !fetch_valid ? 0 : hold_valid ? hold_instr : imem_data.
//   instr_valid = fetch_valid.
//  Stall: pc, pc_plus, fetch_valid held. First stall cycle with hold_valid=0 and fetch_valid=1:
//   hold_instr<=imem_data, hold_valid<=1 (skid capture; memory re-reads pc, not held word).
//   Further stall cycles: hold unchanged. instr stable for entire stall.
//  Stall release: next edge is a normal advance; hold_valid cleared on that edge, so
//   held word consumed exactly once, no duplicate, no drop.
//  Branch (overrides stall): pc<=branch_target; fetch_valid<=0; hold_valid<=0; pc_plus held.
//   Cycle after branch: instr_valid=0 (one bubble). Cycle after that: word at branch_target
//   valid, pc_plus=branch_target+PC_INC. Back-to-back branches: last target wins, bubbles continue.
//  Arithmetic: pc+PC_INC modulo 2^DATA_W (wraps, no flag). imem_addr truncates pc to ADDR_W bits;
//   fetch past 2^ADDR_W-1 wraps memory address to 0 while pc_debug keeps full value.
//  Simultaneous stall+branch: branch taken, stall ignored that cycle.
// TESTING
//  T1 reset: rst=1 2 cycles, RESET_PC=0 -> instr_valid=0, instr=0, pc_debug=0; release ->
//     next cycle instr=mem[0], pc_plus=1, then mem[1], pc_plus=2 each cycle.
//  T2 stall: stall=1 for 3 cycles while instr=mem[4] valid -> instr=mem[4], pc_plus=5,
//     pc_debug=5 all 3 cycles; release -> mem[5] next, no repeat/skip of mem[4]/mem[5].
//  T3 branch: branch_taken=1, target=0x40 while pc=7 -> next cycle instr_valid=0, pc_debug=0x40;
//     following cycle instr=mem[0x40], pc_plus=0x41.
//  T4 stall+branch same cycle (target=0x10) -> branch wins: bubble, then mem[0x10]; held word dropped.
//  T5 wrap: ADDR_W=10, pc=0x3FF -> imem_addr 0x3FF then 0x000, pc_debug=0x400;
//     pc=0xFFFFFFFF -> next pc_debug=0, pc_plus=0.
//  T6 reset during stall with hold_valid=1 -> instr_valid=0, hold cleared, restart at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous instruction memory and
// presents instr/pc_plus/instr_valid to IF/ID, with stall skid-hold and branch redirect.
module instruction_fetch_stage #(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        ADDR_W   = 10,
  parameter int unsigned        PC_INC   = 1,
  parameter logic [DATA_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [DATA_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] pc_debug,
  output logic [DATA_W-1:0] pc_plus,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid
);

  localparam logic [DATA_W-1:0] INC = DATA_W'(PC_INC);

  logic [DATA_W-1:0] pc_q,         pc_d;
  logic [DATA_W-1:0] pc_plus_q,    pc_plus_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              hold_valid_q,  hold_valid_d;
  logic [DATA_W-1:0] hold_instr_q,  hold_instr_d;
  logic [DATA_W-1:0] pc_next;

  assign pc_next = pc_q + INC;

  always_comb begin
    // NOTE: every _d gets its current value first so no path leaves it unassigned (no latch).
    pc_d          = pc_q;
    pc_plus_d     = pc_plus_q;
    fetch_valid_d = fetch_valid_q;
    hold_valid_d  = hold_valid_q;
    hold_instr_d  = hold_instr_q;

    if (branch_taken) begin
      pc_d          = branch_target;
      fetch_valid_d = 1'b0;
      hold_valid_d  = 1'b0;
    end else if (stall) begin
      // Memory re-reads pc during a stall, so the word on imem_data must be captured once.
      if (fetch_valid_q && !hold_valid_q) begin
        hold_instr_d = imem_data;
        hold_valid_d = 1'b1;
      end
    end else begin
      pc_d          = pc_next;
      pc_plus_d     = pc_next;
      fetch_valid_d = 1'b1;
      hold_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values of the others.
    if (rst) begin
      pc_q          <= RESET_PC;
      pc_plus_q     <= '0;
      fetch_valid_q <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_instr_q  <= '0;
    end else begin
      pc_q          <= pc_d;
      pc_plus_q     <= pc_plus_d;
      fetch_valid_q <= fetch_valid_d;
      hold_valid_q  <= hold_valid_d;
      hold_instr_q  <= hold_instr_d;
    end
  end

  assign imem_addr   = pc_q[ADDR_W-1:0];
  assign pc_debug    = pc_q;
  assign pc_plus     = pc_plus_q;
  assign instr_valid = fetch_valid_q;
  assign instr       = !fetch_valid_q ? '0 : (hold_valid_q ? hold_instr_q : imem_data);

endmodule
